// File: rtl/bp_fe_bht_update_queue.sv
// In-order queue of in-flight branch predictions feeding BHT updates.
// A resolve pops the head and issues a registered update one cycle later.
module bp_fe_bht_update_queue #(
  parameter int bht_idx_width_p = 4,
  parameter int els_p = 8,
  localparam int ptr_width_lp = $clog2(els_p),
  localparam int cnt_width_lp = $clog2(els_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       enq_v_i,
  input  logic [bht_idx_width_p-1:0] enq_idx_i,
  input  logic                       enq_pred_i,
  output logic                       enq_ready_o,
  input  logic                       resolve_v_i,
  input  logic                       resolve_taken_i,
  input  logic                       flush_i,
  output logic                       w_v_o,
  output logic [bht_idx_width_p-1:0] idx_w_o,
  output logic                       correct_o,
  output logic [cnt_width_lp-1:0]    count_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       underflow_o
);

  typedef struct packed {
    logic [bht_idx_width_p-1:0] idx;
    logic                       pred;
  } entry_t;

  entry_t                  mem [els_p];
  logic [ptr_width_lp-1:0] rd_ptr;
  logic [ptr_width_lp-1:0] wr_ptr;
  logic [ptr_width_lp-1:0] rd_ptr_next;
  logic [cnt_width_lp-1:0] count;
  logic                    enq_fire;
  logic                    deq_fire;
  entry_t                  head;

  assign count_o     = count;
  assign empty_o     = (count == '0);
  assign full_o      = (count == cnt_width_lp'(els_p));
  assign enq_ready_o = ~full_o;

  assign enq_fire    = enq_v_i & enq_ready_o & ~flush_i;
  assign deq_fire    = resolve_v_i & ~empty_o;
  assign rd_ptr_next = rd_ptr + ptr_width_lp'(deq_fire);
  assign head        = mem[rd_ptr];

  // Payload storage carries no reset; count alone defines validity.
  always_ff @(posedge clk_i) begin
    if (enq_fire)
      mem[wr_ptr] <= {enq_idx_i, enq_pred_i};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      w_v_o       <= 1'b0;
      idx_w_o     <= '0;
      correct_o   <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr_next;
      w_v_o  <= deq_fire;
      if (flush_i) begin
        wr_ptr <= rd_ptr_next;
        count  <= '0;
      end else begin
        wr_ptr <= wr_ptr + ptr_width_lp'(enq_fire);
        count  <= count + cnt_width_lp'(enq_fire)
                        - cnt_width_lp'(deq_fire);
      end
      if (deq_fire) begin
        idx_w_o   <= head.idx;
        correct_o <= (head.pred == resolve_taken_i);
      end
      if (resolve_v_i & empty_o)
        underflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bp_fe_bht_update_queue.sv
// Bench for bp_fe_bht_update_queue: directed scenarios then random
// traffic, all compared against a queue-based reference model.
module tb_bp_fe_bht_update_queue;

  localparam int W   = 4;
  localparam int ELS = 8;
  localparam int CW  = $clog2(ELS + 1);

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          enq_v_i;
  logic [W-1:0]  enq_idx_i;
  logic          enq_pred_i;
  logic          enq_ready_o;
  logic          resolve_v_i;
  logic          resolve_taken_i;
  logic          flush_i;
  logic          w_v_o;
  logic [W-1:0]  idx_w_o;
  logic          correct_o;
  logic [CW-1:0] count_o;
  logic          empty_o;
  logic          full_o;
  logic          underflow_o;

  bp_fe_bht_update_queue #(
    .bht_idx_width_p(W),
    .els_p(ELS)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .enq_v_i(enq_v_i),
    .enq_idx_i(enq_idx_i),
    .enq_pred_i(enq_pred_i),
    .enq_ready_o(enq_ready_o),
    .resolve_v_i(resolve_v_i),
    .resolve_taken_i(resolve_taken_i),
    .flush_i(flush_i),
    .w_v_o(w_v_o),
    .idx_w_o(idx_w_o),
    .correct_o(correct_o),
    .count_o(count_o),
    .empty_o(empty_o),
    .full_o(full_o),
    .underflow_o(underflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int idx;
    bit pred;
  } ent_t;

  ent_t q[$];
  bit   exp_wv;
  int   exp_idx;
  bit   exp_cor;
  bit   exp_uf;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("count", int'(count_o), q.size());
    check("empty", int'(empty_o), int'(q.size() == 0));
    check("full", int'(full_o), int'(q.size() == ELS));
    check("ready", int'(enq_ready_o), int'(q.size() < ELS));
    check("w_v", int'(w_v_o), int'(exp_wv));
    check("idx_w", int'(idx_w_o), exp_idx);
    check("correct", int'(correct_o), int'(exp_cor));
    check("underflow", int'(underflow_o), int'(exp_uf));
  endtask

  task automatic idle_inputs();
    enq_v_i = 0; enq_idx_i = '0; enq_pred_i = 0;
    resolve_v_i = 0; resolve_taken_i = 0; flush_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_i = 1;
    @(posedge clk_i); #1;
    reset_i = 0;
    q.delete();
    exp_wv = 0; exp_idx = 0; exp_cor = 0; exp_uf = 0;
    check_all();
  endtask

  // One clock: drive inputs, advance the model, then compare.
  task automatic step(input bit e, input int idx, input bit p,
                      input bit r, input bit t, input bit f);
    bit   rdy;
    ent_t tmp;
    enq_v_i = e; enq_idx_i = W'(idx); enq_pred_i = p;
    resolve_v_i = r; resolve_taken_i = t; flush_i = f;
    rdy = (q.size() < ELS);
    exp_wv = 0;
    if (r) begin
      if (q.size() > 0) begin
        tmp = q.pop_front();
        exp_wv = 1;
        exp_idx = tmp.idx;
        exp_cor = (tmp.pred == t);
      end else begin
        exp_uf = 1;
      end
    end
    if (f) q.delete();
    else if (e && rdy) q.push_back('{idx: idx % (1 << W), pred: p});
    @(posedge clk_i); #1;
    check_all();
  endtask

  task automatic enq(input int idx, input bit p);
    step(1, idx, p, 0, 0, 0);
  endtask

  task automatic res(input bit t);
    step(0, 0, 0, 1, t, 0);
  endtask

  initial begin
    reset_i = 0;
    idle_inputs();
    do_reset();

    // Ordering
    enq(3, 1); enq(5, 0); enq(9, 1);
    res(1); res(1); res(0);
    step(0, 0, 0, 0, 0, 0);

    // Full, dropped enqueue, wrap
    do_reset();
    for (int i = 0; i < 8; i++) enq(i, i[0]);
    enq(15, 1);
    res(0); res(0);
    enq(10, 1); enq(11, 0);
    for (int i = 0; i < 8; i++) res(i[1]);
    step(0, 0, 0, 0, 0, 0);

    // Simultaneous enqueue and resolve
    do_reset();
    for (int i = 0; i < 8; i++) enq(i, 1);
    step(1, 12, 0, 1, 1, 0);
    do_reset();
    for (int i = 0; i < 3; i++) enq(i + 4, 0);
    step(1, 13, 1, 1, 0, 0);
    step(1, 14, 1, 1, 1, 0);

    // Flush with same-cycle resolve and enqueue
    do_reset();
    enq(1, 0); enq(2, 1); enq(3, 1);
    step(1, 4, 1, 1, 0, 1);
    check("flush_idx", int'(idx_w_o), 1);
    enq(6, 1);
    res(1);
    check("post_flush_idx", int'(idx_w_o), 6);

    // Underflow stickiness
    do_reset();
    res(1);
    enq(7, 1); res(1); step(0, 0, 0, 0, 0, 0);
    check("uf_sticky", int'(underflow_o), 1);
    do_reset();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      step($urandom_range(0, 99) < 55, int'($urandom_range(0, 15)),
           1'($urandom), $urandom_range(0, 99) < 45, 1'($urandom),
           $urandom_range(0, 99) < 4);
    end

    idle_inputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_fe_bht_update_queue.md
Name: bp_fe_bht_update_queue

Overview:
- In-order queue of in-flight branch predictions between the FE fetch stage and the branch predictor's BHT update port.
- On every predicted branch fetch, records the BHT index read and the prediction returned.
- When the backend resolves the oldest branch, the head entry is popped and a registered BHT write is issued: w_v_o, idx_w_o and correct_o, driving the predictor's w_v_i, idx_w_i and correct_i.
- Supports a redirect flush that discards all younger, unresolved entries.

Parameters:
- bht_idx_width_p, "inv", BHT index width; must match the predictor.
- els_p, 8, queue depth; power of two, >= 2.
- localparam ptr_width_lp = $clog2(els_p); cnt_width_lp = $clog2(els_p+1).

Ports:
- clk_i  input  1  clock.
- reset_i  input  1  synchronous active-high reset.
- enq_v_i  input  1  predicted branch fetched this cycle.
- enq_idx_i  input  bht_idx_width_p  BHT index used for the prediction.
- enq_pred_i  input  1  prediction made (1 = taken).
- enq_ready_o  output  1  queue can accept; equals ~full_o.
- resolve_v_i  input  1  oldest in-flight branch resolved.
- resolve_taken_i  input  1  actual outcome of the resolved branch.
- flush_i  input  1  redirect; discard all entries not resolved this cycle.
- w_v_o  output  1  BHT update valid.
- idx_w_o  output  bht_idx_width_p  BHT update index.
- correct_o  output  1  1 when the stored prediction equals the actual outcome.
- count_o  output  cnt_width_lp  current occupancy.
- empty_o  output  1  count_o == 0.
- full_o  output  1  count_o == els_p.
- underflow_o  output  1  sticky error: resolve arrived while empty.

Behaviour:
- Single clock domain. Reset is synchronous and active-high. The clock and reset ports are named clk_i and reset_i.
- Reset values:
  - rd_ptr, wr_ptr, count = 0.
  - w_v_o = 0, idx_w_o = 0, correct_o = 0, underflow_o = 0.
  - empty_o = 1, full_o = 0, enq_ready_o = 1.
- Reset mid-operation discards all entries. Any update not yet presented is lost.
- Storage: els_p entries of {idx, pred} in a flop array. Pointers wrap modulo els_p by natural overflow. count is tracked separately, so full and empty are unambiguous.
- Enqueue: fires when enq_v_i & enq_ready_o & ~flush_i.
  - Writes entry[wr_ptr]; wr_ptr++.
  - enq_v_i while full is dropped silently. Upstream must stall on enq_ready_o.
  - No same-cycle bypass: enq_ready_o depends only on the current count, never on resolve_v_i.
- Resolve: fires when resolve_v_i & ~empty_o.
  - Pops entry[rd_ptr]; rd_ptr++.
  - Next cycle: w_v_o = 1, idx_w_o = entry.idx, correct_o = (entry.pred == resolve_taken_i).
  - Latency is exactly 1 cycle from resolve to update. w_v_o is a single-cycle pulse per resolve.
  - In cycles with no resolve, w_v_o = 0. idx_w_o and correct_o hold their previous values.
- resolve_v_i while empty:
  - No pop and no update; w_v_o stays 0.
  - underflow_o sets to 1 and holds until reset.
- Flush: flush_i sets count = 0 and wr_ptr = rd_ptr_next, where rd_ptr_next accounts for a same-cycle resolve.
  - A resolve in the flush cycle is processed first; its update is still issued next cycle.
  - Any enqueue in the flush cycle is discarded.
- Simultaneous enqueue and resolve (no flush):
  - Both take effect; count is unchanged.
  - Legal when full (resolve pops, enqueue blocked because enq_ready_o = 0) and when count == 1.
- count_o, empty_o, full_o and enq_ready_o are combinational from registered count.

Test Plan:
- Reset: after reset, empty_o = 1, enq_ready_o = 1, count_o = 0, w_v_o = 0, underflow_o = 0.
- Ordering (bht_idx_width_p = 4): enqueue (idx 3, pred 1), (idx 5, pred 0), (idx 9, pred 1); resolve taken 1, 1, 0 on consecutive cycles -> w_v_o pulses on the three following cycles with (idx_w_o, correct_o) = (3,1), (5,0), (9,0); count_o ends at 0.
- Full/wrap (els_p = 8): enqueue idx 0..7 -> full_o = 1, enq_ready_o = 0. A 9th enqueue (idx 15) is dropped. Resolve 2, then enqueue idx 10, 11. Resolve all 8 -> updates arrive in idx order 2..7, 10, 11.
- Simultaneous: with count 8, assert resolve_v_i and enq_v_i -> pop happens, enqueue blocked, count_o = 7. With count 3, assert both -> count stays 3.
- Flush: enqueue idx 1, 2, 3; in one cycle assert resolve_v_i (taken 0), flush_i and enq_v_i (idx 4) -> next cycle w_v_o = 1, idx_w_o = 1; count_o = 0; a subsequent enqueue of idx 6 followed by a resolve yields idx_w_o = 6.
- Underflow: resolve_v_i while empty -> w_v_o stays 0, underflow_o = 1 and stays 1 through later normal traffic; a later reset clears it.
